jesd204_soft_pcs_rx_align_ctrl: RTL and testbench
=================================================

JESD204_SOFT_PCS_RX_ALIGN_CTRL -- requirements
Module: jesd204_soft_pcs_rx_align_ctrl

Interface
REQ-001 Parameters SHALL be:
- NUM_LANES, default 1: number of lanes.
- DATA_PATH_WIDTH, default 4: characters per lane per beat.
- LOCK_CNT, default 4: clean K28.5 beats needed for lock, range 1..255.
- ERR_THRESH, default 3: error score that drops lock, range 1..15.
- DECAY_CNT, default 8: consecutive clean beats that decrement the error score, range 1..255.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: the single clock.
- resetn, in, 1: asynchronous, active-low reset.
- en, in, 1: link enable.
- char, in, NUM_LANES*DATA_PATH_WIDTH*8: decoded characters from the soft PCS.
- charisk, in, NUM_LANES*DATA_PATH_WIDTH: K-character flags.
- notintable, in, NUM_LANES*DATA_PATH_WIDTH: not-in-table flags.
- disperr, in, NUM_LANES*DATA_PATH_WIDTH: disparity-error flags.
- patternalign_en, out, NUM_LANES: per-lane aligner enable.
- patternalign_en_any, out, 1: OR of patternalign_en, for the shared PCS enable.
- lane_locked, out, NUM_LANES: lane is in LOCKED.
- all_locked, out, 1: AND of lane_locked.
- lane_state, out, 2*NUM_LANES: per-lane state code.

Function
REQ-003 Each lane SHALL run an independent FSM with states IDLE=0, HUNT=1, VERIFY=2, LOCKED=3, reported on lane_state[2*l+:2].
REQ-004 Per beat and per lane: err = OR of that lane's notintable|disperr bits; k285 = any character with charisk=1 and char=8'hBC.
REQ-005 en=0 SHALL force every lane to IDLE on the next edge and clear its counters, overriding all other transitions.
REQ-006 Transitions:
- IDLE -> HUNT when en=1.
- HUNT -> VERIFY when k285 and !err.
- VERIFY -> HUNT when err.
- VERIFY -> LOCKED when the good-beat count reaches LOCK_CNT.
- LOCKED -> HUNT when the error score reaches ERR_THRESH.
REQ-007 VERIFY good-beat count: +1 on k285&&!err; held on !k285&&!err; cleared on entering VERIFY; LOCK_CNT=1 locks on the first qualifying beat after entry.
REQ-008 LOCKED error score:
- Saturating at ERR_THRESH.
- +1 on each err beat; an err beat also clears the clean-run counter.
- On each clean beat the clean-run counter increments; on reaching DECAY_CNT it wraps to 0 and the score decrements, floored at 0.
- Both counters are cleared on entering LOCKED.
REQ-009 An err beat whose score reaches ERR_THRESH SHALL cause HUNT on the same edge, with no decay applied that edge.
REQ-010 Outputs SHALL be registered Moore outputs:
- patternalign_en[l] = (state==HUNT).
- lane_locked[l] = (state==LOCKED).
- Combined outputs follow the registered state with 0 extra cycles.
- Input beat to state/output change latency is exactly 1 clk.
REQ-011 Input flag pipelining from the PCS SHALL NOT be compensated; VERIFY tolerates it by requiring LOCK_CNT beats.
REQ-012 Counter widths SHALL be the minimum that holds the parameter value; no counter may wrap except the decay wrap in REQ-008.

Reset
REQ-013 resetn=0 SHALL asynchronously force:
- all lanes to IDLE and all counters to 0;
- patternalign_en, patternalign_en_any, lane_locked, all_locked to 0;
- lane_state to all zeros.
Release SHALL be taken synchronously by the integrator.
REQ-014 Reset mid-lock SHALL drop lane_locked immediately, without waiting for a clock.

Structure
REQ-015 State encodings and the K28.5 code 8'hBC SHALL live in the shared jesd204 package/include.
REQ-016 The per-lane FSM SHALL be a sub-module, jesd204_rx_align_lane_fsm, instantiated NUM_LANES times; the top holds only the flag reduction and output combination.

Verification
REQ-017 Acquire: en=1, clean K28.5 beats on lane 0 with defaults -> IDLE, HUNT, VERIFY; lane_locked=1 on the 5th edge after the first K28.5 beat.
REQ-018 Verify abort: after 2 good beats, one notintable beat -> HUNT next cycle, patternalign_en=1, count restarts.
REQ-019 Loss of lock: LOCKED, then 3 err beats separated by 2 clean beats -> HUNT after the third; with 8 clean beats between errors, lock holds.
REQ-020 Multi-lane: NUM_LANES=4, lane 2 held in error -> all_locked=0, patternalign_en_any=1, lanes 0/1/3 locked.
REQ-021 Reset/enable: resetn low mid-LOCKED -> outputs 0 without a clk edge; en=0 in VERIFY -> IDLE next cycle, counters 0.

Source files
------------

// File: rtl/jesd204_pkg.sv
// Shared JESD204 definitions for the soft-PCS receive alignment control:
// per-lane alignment state codes, the K28.5 comma code and a counter sizing helper.
package jesd204_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_VERIFY = 2'd2,
      ST_LOCKED = 2'd3
   } align_state_e;

   localparam logic [7:0] K28_5 = 8'hBC;

   // Smallest counter width able to hold max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/jesd204_rx_align_lane_fsm.sv
// Per-lane comma alignment FSM: IDLE -> HUNT -> VERIFY -> LOCKED with a
// leaky-bucket error score that drops lock after ERR_THRESH net errors.
module jesd204_rx_align_lane_fsm
   import jesd204_pkg::*;
#(
   parameter int LOCK_CNT   = 4,
   parameter int ERR_THRESH = 3,
   parameter int DECAY_CNT  = 8
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       en,
   input  logic       k285,
   input  logic       err,
   output logic [1:0] state,
   output logic       patternalign_en,
   output logic       locked
);

   localparam int GOOD_W  = cnt_width(LOCK_CNT);
   localparam int SCORE_W = cnt_width(ERR_THRESH);
   localparam int CLEAN_W = cnt_width(DECAY_CNT);

   localparam logic [GOOD_W-1:0]  LOCK_V   = GOOD_W'(LOCK_CNT);
   localparam logic [SCORE_W-1:0] THRESH_V = SCORE_W'(ERR_THRESH);
   localparam logic [CLEAN_W-1:0] DECAY_V  = CLEAN_W'(DECAY_CNT);

   align_state_e       state_q, state_d;
   logic [GOOD_W-1:0]  good_q, good_d, good_inc;
   logic [SCORE_W-1:0] score_q, score_d, score_inc;
   logic [CLEAN_W-1:0] clean_q, clean_d, clean_inc;
   logic               pa_q, pa_d;
   logic               locked_q, locked_d;

   // Next-state, counter updates and Moore output decode from the next state.
   always_comb begin
      state_d   = state_q;
      good_d    = good_q;
      score_d   = score_q;
      clean_d   = clean_q;
      // Counters never exceed their limit while in use, so the increments cannot overflow.
      good_inc  = good_q + GOOD_W'(1);
      score_inc = (score_q == THRESH_V) ? score_q : score_q + SCORE_W'(1);
      clean_inc = clean_q + CLEAN_W'(1);

      if (!en) begin
         state_d = ST_IDLE;
         good_d  = '0;
         score_d = '0;
         clean_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_HUNT;
            end
            ST_HUNT: begin
               if (k285 && !err) begin
                  state_d = ST_VERIFY;
                  good_d  = '0;
               end
            end
            ST_VERIFY: begin
               if (err) begin
                  state_d = ST_HUNT;
                  good_d  = '0;
               end else if (k285) begin
                  if (good_inc == LOCK_V) begin
                     state_d = ST_LOCKED;
                     good_d  = '0;
                     score_d = '0;
                     clean_d = '0;
                  end else begin
                     good_d = good_inc;
                  end
               end
            end
            ST_LOCKED: begin
               if (err) begin
                  // An error beat never decays; it may drop lock on this same edge.
                  clean_d = '0;
                  if (score_inc == THRESH_V) begin
                     state_d = ST_HUNT;
                     score_d = '0;
                  end else begin
                     score_d = score_inc;
                  end
               end else if (clean_inc == DECAY_V) begin
                  clean_d = '0;
                  if (score_q != '0) begin
                     score_d = score_q - SCORE_W'(1);
                  end
               end else begin
                  clean_d = clean_inc;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      pa_d     = (state_d == ST_HUNT);
      locked_d = (state_d == ST_LOCKED);
   end

   // State, counters and registered outputs; reset clears everything immediately.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         good_q   <= '0;
         score_q  <= '0;
         clean_q  <= '0;
         pa_q     <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         good_q   <= good_d;
         score_q  <= score_d;
         clean_q  <= clean_d;
         pa_q     <= pa_d;
         locked_q <= locked_d;
      end
   end

   assign state           = state_q;
   assign patternalign_en = pa_q;
   assign locked          = locked_q;

endmodule

// File: rtl/jesd204_soft_pcs_rx_align_ctrl.sv
// Soft-PCS receive alignment control: reduces per-lane character flags to
// k285/err per beat, runs one alignment FSM per lane and combines lane status.
module jesd204_soft_pcs_rx_align_ctrl
   import jesd204_pkg::*;
#(
   parameter int NUM_LANES       = 1,
   parameter int DATA_PATH_WIDTH = 4,
   parameter int LOCK_CNT        = 4,
   parameter int ERR_THRESH      = 3,
   parameter int DECAY_CNT       = 8
) (
   input  logic                                   clk,
   input  logic                                   resetn,
   input  logic                                   en,
   input  logic [NUM_LANES*DATA_PATH_WIDTH*8-1:0] char,
   input  logic [NUM_LANES*DATA_PATH_WIDTH-1:0]   charisk,
   input  logic [NUM_LANES*DATA_PATH_WIDTH-1:0]   notintable,
   input  logic [NUM_LANES*DATA_PATH_WIDTH-1:0]   disperr,
   output logic [NUM_LANES-1:0]                   patternalign_en,
   output logic                                   patternalign_en_any,
   output logic [NUM_LANES-1:0]                   lane_locked,
   output logic                                   all_locked,
   output logic [2*NUM_LANES-1:0]                 lane_state
);

   logic [NUM_LANES-1:0] lane_k285;
   logic [NUM_LANES-1:0] lane_err;

   // Per-lane reduction: any K28.5 character, any table or disparity error.
   always_comb begin
      lane_k285 = '0;
      lane_err  = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         for (int c = 0; c < DATA_PATH_WIDTH; c++) begin
            if (charisk[l*DATA_PATH_WIDTH+c] &&
                (char[(l*DATA_PATH_WIDTH+c)*8 +: 8] == K28_5)) begin
               lane_k285[l] = 1'b1;
            end
            if (notintable[l*DATA_PATH_WIDTH+c] || disperr[l*DATA_PATH_WIDTH+c]) begin
               lane_err[l] = 1'b1;
            end
         end
      end
   end

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      jesd204_rx_align_lane_fsm #(
         .LOCK_CNT   (LOCK_CNT),
         .ERR_THRESH (ERR_THRESH),
         .DECAY_CNT  (DECAY_CNT)
      ) u_fsm (
         .clk             (clk),
         .resetn          (resetn),
         .en              (en),
         .k285            (lane_k285[l]),
         .err             (lane_err[l]),
         .state           (lane_state[2*l +: 2]),
         .patternalign_en (patternalign_en[l]),
         .locked          (lane_locked[l])
      );
   end

   assign patternalign_en_any = |patternalign_en;
   assign all_locked          = &lane_locked;

endmodule

// File: tb/tb_jesd204_soft_pcs_rx_align_ctrl.sv
// Scoreboard bench for the alignment control: the driver applies one beat per
// cycle and queues the hand-derived lane states expected after the next edge;
// the monitor pops and compares after every rising edge.
module tb_jesd204_soft_pcs_rx_align_ctrl;

   localparam int NL  = 4;
   localparam int DPW = 4;

   // Beat kinds per lane
   localparam logic [2:0] C_DAT  = 3'd0; // plain data, no flags
   localparam logic [2:0] C_K    = 3'd1; // K28.5 in byte 0
   localparam logic [2:0] C_KNIT = 3'd2; // K28.5 in byte 0, notintable on byte 1
   localparam logic [2:0] C_DERR = 3'd3; // disparity error on byte 3
   localparam logic [2:0] C_BCD  = 3'd4; // 0xBC as data (charisk=0)
   localparam logic [2:0] C_K3   = 3'd5; // K28.5 in byte 3
   localparam logic [2:0] C_K7   = 3'd6; // K28.3 (0x7C) in byte 1

   localparam logic [1:0] S_I = 2'd0;
   localparam logic [1:0] S_H = 2'd1;
   localparam logic [1:0] S_V = 2'd2;
   localparam logic [1:0] S_L = 2'd3;

   logic                  clk = 1'b0;
   logic                  resetn = 1'b0;
   logic                  en = 1'b0;
   logic [NL*DPW*8-1:0]   char_i;
   logic [NL*DPW-1:0]     charisk_i, notintable_i, disperr_i;
   logic [NL-1:0]         pa, locked;
   logic                  pa_any, all_locked;
   logic [2*NL-1:0]       lane_state;

   typedef struct packed {
      logic [15:0] id;
      logic [7:0]  st;
      logic [9:0]  flags;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   int   beat_no = 0;

   jesd204_soft_pcs_rx_align_ctrl #(
      .NUM_LANES       (NL),
      .DATA_PATH_WIDTH (DPW),
      .LOCK_CNT        (4),
      .ERR_THRESH      (3),
      .DECAY_CNT       (8)
   ) dut (
      .clk                 (clk),
      .resetn              (resetn),
      .en                  (en),
      .char                (char_i),
      .charisk             (charisk_i),
      .notintable          (notintable_i),
      .disperr             (disperr_i),
      .patternalign_en     (pa),
      .patternalign_en_any (pa_any),
      .lane_locked         (locked),
      .all_locked          (all_locked),
      .lane_state          (lane_state)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
      $fatal(1);
   end

   function automatic logic [11:0] k4(input logic [2:0] a, input logic [2:0] b,
                                      input logic [2:0] c, input logic [2:0] d);
      return {d, c, b, a};
   endfunction

   function automatic logic [7:0] s4(input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] c, input logic [1:0] d);
      return {d, c, b, a};
   endfunction

   // Expected {patternalign_en, any, lane_locked, all} implied by lane states.
   function automatic logic [9:0] flags_of(input logic [7:0] st);
      logic [3:0] p, k;
      for (int l = 0; l < NL; l++) begin
         p[l] = (st[2*l +: 2] == S_H);
         k[l] = (st[2*l +: 2] == S_L);
      end
      return {p, |p, k, &k};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp, input int id);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s beat %0d: got %h, expected %h", name, id, act, exp);
      end
   endtask

   task automatic drive_lane(input int l, input logic [2:0] kind);
      for (int b = 0; b < DPW; b++) begin
         char_i[(l*DPW+b)*8 +: 8] = 8'h4A;
         charisk_i[l*DPW+b]       = 1'b0;
         notintable_i[l*DPW+b]    = 1'b0;
         disperr_i[l*DPW+b]       = 1'b0;
      end
      case (kind)
         C_K:    begin char_i[(l*DPW+0)*8 +: 8] = 8'hBC; charisk_i[l*DPW+0] = 1'b1; end
         C_KNIT: begin char_i[(l*DPW+0)*8 +: 8] = 8'hBC; charisk_i[l*DPW+0] = 1'b1;
                       notintable_i[l*DPW+1] = 1'b1; end
         C_DERR: begin disperr_i[l*DPW+3] = 1'b1; end
         C_BCD:  begin char_i[(l*DPW+2)*8 +: 8] = 8'hBC; end
         C_K3:   begin char_i[(l*DPW+3)*8 +: 8] = 8'hBC; charisk_i[l*DPW+3] = 1'b1; end
         C_K7:   begin char_i[(l*DPW+1)*8 +: 8] = 8'h7C; charisk_i[l*DPW+1] = 1'b1; end
         default: ;
      endcase
   endtask

   // One beat: drive at the falling edge, queue the state expected after the next rising edge.
   task automatic beat(input logic en_i, input logic [11:0] kinds, input logic [7:0] exp_st);
      exp_t x;
      en = en_i;
      for (int l = 0; l < NL; l++) drive_lane(l, kinds[3*l +: 3]);
      beat_no++;
      x.id    = 16'(beat_no);
      x.st    = exp_st;
      x.flags = flags_of(exp_st);
      q.push_back(x);
      @(negedge clk);
   endtask

   // Lane 0 gets kind k, lanes 1..3 plain data (they sit in HUNT).
   task automatic b0(input logic [2:0] k, input logic [1:0] s);
      beat(1'b1, k4(k, C_DAT, C_DAT, C_DAT), s4(s, S_H, S_H, S_H));
   endtask

   // Monitor: compare outputs after each rising edge against the queued expectation.
   initial forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("lane_state", 16'(lane_state), 16'(e.st), int'(e.id));
         check("status", 16'({pa, pa_any, locked, all_locked}), 16'(e.flags), int'(e.id));
      end
   end

   initial begin
      for (int l = 0; l < NL; l++) drive_lane(l, C_DAT);
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 16'(lane_state), 16'h0000, 0);
      check("reset_status", 16'({pa, pa_any, locked, all_locked}), 16'h0000, 0);
      @(negedge clk);
      resetn = 1'b1;

      beat(1'b0, k4(C_DAT, C_DAT, C_DAT, C_DAT), s4(S_I, S_I, S_I, S_I));
      beat(1'b1, k4(C_DAT, C_DAT, C_DAT, C_DAT), s4(S_H, S_H, S_H, S_H));

      // Acquire: lock on the 5th edge after the first K28.5 beat
      b0(C_K, S_V); b0(C_K, S_V); b0(C_K3, S_V); b0(C_K, S_V); b0(C_K, S_L);

      // Loss of lock: three errors two clean beats apart
      b0(C_DERR, S_L); b0(C_DAT, S_L); b0(C_DAT, S_L);
      b0(C_KNIT, S_L); b0(C_DAT, S_L); b0(C_DAT, S_L);
      b0(C_DERR, S_H);
      b0(C_KNIT, S_H); b0(C_DAT, S_H);

      // Relock, then eight clean beats between errors keep the score low
      b0(C_K, S_V); repeat (3) b0(C_K, S_V); b0(C_K, S_L);
      b0(C_DERR, S_L); repeat (8) b0(C_DAT, S_L);
      b0(C_DERR, S_L); repeat (8) b0(C_DAT, S_L);
      b0(C_DERR, S_L); b0(C_DERR, S_L); b0(C_DERR, S_H);

      // Relock; decay at score 0 floors; seven clean beats are not enough to decay
      b0(C_K, S_V); repeat (3) b0(C_K, S_V); b0(C_K, S_L);
      repeat (8) b0(C_DAT, S_L);
      b0(C_DERR, S_L); repeat (7) b0(C_DAT, S_L);
      b0(C_DERR, S_L); repeat (7) b0(C_DAT, S_L);
      b0(C_DERR, S_H);

      // Verify abort after two good beats, count restarts; non-K28.5 beats hold
      b0(C_K, S_V); b0(C_K, S_V); b0(C_K, S_V);
      b0(C_KNIT, S_H);
      b0(C_K, S_V); b0(C_K, S_V); b0(C_BCD, S_V); b0(C_K7, S_V);
      b0(C_K, S_V); b0(C_K, S_V); b0(C_K, S_L);

      // en low from LOCKED and from VERIFY returns to IDLE next cycle
      beat(1'b0, k4(C_K, C_DAT, C_DAT, C_DAT), s4(S_I, S_I, S_I, S_I));
      beat(1'b1, k4(C_DAT, C_DAT, C_DAT, C_DAT), s4(S_H, S_H, S_H, S_H));
      b0(C_K, S_V); b0(C_K, S_V); b0(C_K, S_V);
      beat(1'b0, k4(C_K, C_DAT, C_DAT, C_DAT), s4(S_I, S_I, S_I, S_I));
      beat(1'b1, k4(C_K, C_DAT, C_DAT, C_DAT), s4(S_H, S_H, S_H, S_H));
      b0(C_K, S_V); repeat (3) b0(C_K, S_V); b0(C_K, S_L);

      // Multi-lane: lane 2 held in error while the others lock
      beat(1'b0, k4(C_DAT, C_DAT, C_DAT, C_DAT), s4(S_I, S_I, S_I, S_I));
      beat(1'b1, k4(C_DAT, C_DAT, C_DAT, C_DAT), s4(S_H, S_H, S_H, S_H));
      repeat (4) beat(1'b1, k4(C_K, C_K, C_KNIT, C_K3), s4(S_V, S_V, S_H, S_V));
      beat(1'b1, k4(C_K, C_K, C_KNIT, C_K3), s4(S_L, S_L, S_H, S_L));
      repeat (4) beat(1'b1, k4(C_DAT, C_DAT, C_K, C_DAT), s4(S_L, S_L, S_V, S_L));
      beat(1'b1, k4(C_DAT, C_DAT, C_K, C_DAT), s4(S_L, S_L, S_L, S_L));

      // Reset mid-lock drops everything without a clock edge
      @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check("async_rst_state", 16'(lane_state), 16'h0000, beat_no);
      check("async_rst_status", 16'({pa, pa_any, locked, all_locked}), 16'h0000, beat_no);
      @(negedge clk);
      resetn = 1'b1;
      beat(1'b1, k4(C_DAT, C_DAT, C_DAT, C_DAT), s4(S_H, S_H, S_H, S_H));

      @(posedge clk);
      #3;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
